move_input_ctrl: RTL and testbench
==================================

Name: move_input_ctrl

Overview:
- Direction front-end for the snake game; sits directly upstream of the display/snake-state stage and drives its 3-bit `inmove` input.
- Synchronises and debounces the four direction buttons, then turns presses into single events.
- Rejects same-direction and 180° reversal requests, and queues up to two turns.
- Commits one queued turn per snake step tick, so fast double-taps are not lost between ticks.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronised button level must hold before it is accepted (minimum 2).
- QUEUE_DEPTH, 2, pending-turn queue entries (fixed at 2; exists for documentation/assertions only).

Ports:
- clk  in  1  system clock
- resetButton_n  in  1  asynchronous, active-low reset
- btn_right  in  1  raw button, request +x
- btn_down  in  1  raw button, request -y
- btn_left  in  1  raw button, request -x
- btn_up  in  1  raw button, request +y
- step_tick  in  1  one-clk pulse, asserted once per snake step, synchronous to clk
- game_over  in  1  level, high while the game-over condition holds
- inmove  out  3  committed direction: 000 +x, 001 -y, 010 -x, 011 +y, 100 idle/home
- queue_level  out  2  pending turns, 0..2
- started  out  1  high once a real direction has been committed since reset/game over

Behaviour:
- Reset (resetButton_n low, async, takes effect immediately): inmove=100, queue_level=0, started=0, all synchroniser flops, debounced levels and debounce counters 0.
- Synchroniser: 2-flop synchroniser per button; "sync" below means the second flop's output.
- Debounce, per button:
  - Counter clears whenever sync equals the debounced level.
  - Counter increments while they differ.
  - When the counter would reach DEBOUNCE_CYCLES, the debounced level takes the sync value and the counter clears.
  - Press event = debounced level rising 0->1, one cycle. Releases generate nothing.
- Simultaneous press events in one cycle: priority right > down > left > up. Only the winner is considered; the others are dropped, not deferred.
- Reference direction = newest queue entry if queue_level>0, else inmove. It is evaluated on pre-update state.
- Press acceptance:
  - A press is rejected if it equals the reference or is its opposite (000<->010, 001<->011).
  - If the reference is 100, every direction except 010 is accepted, because the body lies at -x of the head at home.
  - A press is also rejected if the queue is full, unless step_tick pops in the same cycle.
- Queue: 2-entry FIFO. Push writes to the tail; pop takes the head.
- step_tick with queue_level>0: inmove <= head entry, pop, started <= 1.
- step_tick with an empty queue: inmove unchanged.
- Same-cycle push and pop:
  - Both occur; level is unchanged.
  - A push into an empty queue is not bypassed to inmove; it commits on the next tick.
- game_over high (priority over step_tick and presses), each cycle: inmove <= 100, queue flushed to 0, started <= 0, press events discarded. Debounce logic keeps running.
- After game_over falls: normal operation resumes from the idle state.
- Latency:
  - Button held clean from cycle t: press event at t+2+DEBOUNCE_CYCLES, and queue_level increments the following cycle.
  - Committed direction appears on inmove the cycle after the step_tick that pops it.
- All outputs registered; no combinational path from inputs to outputs.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset release, no buttons, 5 step_ticks -> inmove=100, queue_level=0, started=0 throughout.
- btn_up held 10 cycles, then step_tick -> queue_level 1 at cycle 7, then 0 after the tick; inmove=011, started=1.
- btn_right bounces (1,0,1,0 per cycle) then settles high -> exactly one press event; with inmove=100 it is accepted and the next step_tick gives inmove=000.
- inmove=000; press left, then press up before any tick -> left rejected (queue_level stays 0), up accepted (queue_level=1); tick gives inmove=011.
- inmove=000; press down, then up, then right (all before a tick):
  - down accepted, queue_level=1;
  - up rejected as the opposite of newest entry 001;
  - right accepted, queue_level=2;
  - two ticks yield inmove 001 then 000.
- Queue full (001,000) and game_over pulses one cycle together with step_tick and a new press -> inmove=100, queue_level=0, started=0 next cycle.
- Reset asserted mid-debounce -> inmove=100 immediately; no press event after release until a fresh DEBOUNCE_CYCLES-long hold.

Source files
------------

// File: rtl/move_input_ctrl.sv
// Snake direction front-end: synchronise, debounce and edge-detect four buttons,
// filter illegal turns and queue up to two, committing one per step tick.
module move_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int QUEUE_DEPTH     = 2
) (
    input  logic       clk,
    input  logic       resetButton_n,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_up,
    input  logic       step_tick,
    input  logic       game_over,
    output logic [2:0] inmove,
    output logic [1:0] queue_level,
    output logic       started
);

    localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CMAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]      FULL = 2'(QUEUE_DEPTH);
    localparam logic [2:0]      HOME = 3'b100;

    logic [3:0]    w_raw;
    logic [3:0]    r_sync1, r_sync2, r_deb, r_deb_d;
    logic [CW-1:0] r_cnt [4];
    logic [3:0]    w_rise;

    logic [2:0] r_inmove, r_q0, r_q1;
    logic [1:0] r_level;
    logic       r_started;

    logic       w_ev_valid, w_legal, w_push, w_pop;
    logic [2:0] w_ev_dir, w_ref, w_opp;
    logic [2:0] w_inmove_n, w_q0_n, w_q1_n;
    logic [1:0] w_level_n;
    logic       w_started_n;

    assign w_raw  = {btn_up, btn_left, btn_down, btn_right};
    assign w_rise = r_deb & ~r_deb_d;

    always_ff @(posedge clk or negedge resetButton_n) begin
        if (!resetButton_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CMAX) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Lowest button index wins; losers are dropped.
    always_comb begin
        w_ev_valid = 1'b1;
        w_ev_dir   = 3'b000;
        if (w_rise[0])      w_ev_dir = 3'b000;
        else if (w_rise[1]) w_ev_dir = 3'b001;
        else if (w_rise[2]) w_ev_dir = 3'b010;
        else if (w_rise[3]) w_ev_dir = 3'b011;
        else                w_ev_valid = 1'b0;
    end

    assign w_ref = (r_level == 2'd0) ? r_inmove :
                   (r_level == 2'd1) ? r_q0 : r_q1;
    assign w_opp = {w_ref[2], ~w_ref[1], w_ref[0]};

    // At home the body trails at -x, so only -x is illegal.
    assign w_legal = (w_ref == HOME) ? (w_ev_dir != 3'b010)
                   : (w_ev_dir != w_ref) && (w_ev_dir != w_opp);

    assign w_pop  = step_tick && (r_level != 2'd0);
    assign w_push = w_ev_valid && w_legal && !game_over &&
                    ((r_level != FULL) || step_tick);

    always_comb begin
        w_inmove_n  = r_inmove;
        w_q0_n      = r_q0;
        w_q1_n      = r_q1;
        w_level_n   = r_level;
        w_started_n = r_started;
        if (game_over) begin
            w_inmove_n  = HOME;
            w_level_n   = 2'd0;
            w_started_n = 1'b0;
        end else begin
            if (w_pop) begin
                w_inmove_n  = r_q0;
                w_started_n = 1'b1;
            end
            case ({w_push, w_pop})
                2'b11: begin
                    if (r_level == 2'd1) begin
                        w_q0_n = w_ev_dir;
                    end else begin
                        w_q0_n = r_q1;
                        w_q1_n = w_ev_dir;
                    end
                end
                2'b01: begin
                    w_q0_n    = r_q1;
                    w_level_n = r_level - 2'd1;
                end
                2'b10: begin
                    if (r_level == 2'd0) w_q0_n = w_ev_dir;
                    else                 w_q1_n = w_ev_dir;
                    w_level_n = r_level + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetButton_n) begin
        if (!resetButton_n) begin
            r_inmove  <= HOME;
            r_q0      <= '0;
            r_q1      <= '0;
            r_level   <= '0;
            r_started <= 1'b0;
        end else begin
            r_inmove  <= w_inmove_n;
            r_q0      <= w_q0_n;
            r_q1      <= w_q1_n;
            r_level   <= w_level_n;
            r_started <= w_started_n;
        end
    end

    assign inmove      = r_inmove;
    assign queue_level = r_level;
    assign started     = r_started;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Bench for move_input_ctrl: reset/latency vector table, directed turn
// sequences and a randomized run against a queue-based reference model.
module tb_move_input_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       resetButton_n;
    logic [3:0] btn;
    logic       step_tick, game_over;
    logic [2:0] inmove;
    logic [1:0] queue_level;
    logic       started;

    move_input_ctrl #(.DEBOUNCE_CYCLES(D), .QUEUE_DEPTH(2)) dut (
        .clk(clk),
        .resetButton_n(resetButton_n),
        .btn_right(btn[0]),
        .btn_down(btn[1]),
        .btn_left(btn[2]),
        .btn_up(btn[3]),
        .step_tick(step_tick),
        .game_over(game_over),
        .inmove(inmove),
        .queue_level(queue_level),
        .started(started)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit mchk  = 1'b0;

    // Reference model: button index equals its direction code.
    bit [3:0] m_s1, m_s2, m_deb, m_prev;
    int       m_cnt [4];
    int       m_q [$];
    int       m_inmove;
    bit       m_started;

    task automatic chk(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_prev = '0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_q.delete();
        m_inmove  = 4;
        m_started = 1'b0;
    endtask

    task automatic model_step();
        int ev;
        int rf;
        bit ok;
        ev = -1;
        for (int i = 0; i < 4; i++)
            if (ev < 0 && m_deb[i] && !m_prev[i]) ev = i;
        if (game_over) begin
            m_q.delete();
            m_inmove  = 4;
            m_started = 1'b0;
        end else begin
            rf = (m_q.size() > 0) ? m_q[$] : m_inmove;
            ok = (ev >= 0);
            if (ok) begin
                if (rf == 4) ok = (ev != 2);
                else         ok = (ev != rf) && (ev != (rf ^ 2));
            end
            if (m_q.size() == 2 && !step_tick) ok = 1'b0;
            if (step_tick && m_q.size() > 0) begin
                m_inmove  = m_q.pop_front();
                m_started = 1'b1;
            end
            if (ok) m_q.push_back(ev);
        end
        for (int i = 0; i < 4; i++) begin
            m_prev[i] = m_deb[i];
            if (m_s2[i] == m_deb[i]) begin
                m_cnt[i] = 0;
            end else begin
                m_cnt[i]++;
                if (m_cnt[i] == D) begin
                    m_deb[i] = m_s2[i];
                    m_cnt[i] = 0;
                end
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = btn[i];
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        if (mchk) begin
            chk("m_inmove", 8'(inmove), 8'(m_inmove));
            chk("m_level", 8'(queue_level), 8'(m_q.size()));
            chk("m_started", 8'(started), 8'(m_started));
        end
    endtask

    task automatic tick();
        step_tick = 1'b1;
        cyc();
        step_tick = 1'b0;
    endtask

    task automatic press(input int b);
        btn[b] = 1'b1;
        repeat (D + 3) cyc();
        btn[b] = 1'b0;
        repeat (D + 4) cyc();
    endtask

    task automatic do_reset();
        resetButton_n = 1'b0;
        #1;
        model_reset();
        chk("rst_inmove", 8'(inmove), 8'd4);
        chk("rst_level", 8'(queue_level), 8'd0);
        chk("rst_started", 8'(started), 8'd0);
        @(posedge clk);
        @(negedge clk);
        resetButton_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] b;
        bit         t;
        bit         g;
        logic [2:0] inm;
        logic [1:0] lvl;
        bit         st;
    } vec_t;

    vec_t tbl [$];

    initial begin
        vec_t v;
        bit   seen;
        btn = '0; step_tick = 1'b0; game_over = 1'b0;
        resetButton_n = 1'b0;
        model_reset();

        // Idle ticks after reset, then btn_up held 10 cycles, then a tick.
        for (int k = 0; k < 5; k++) tbl.push_back('{4'b0000, 1, 0, 3'd4, 2'd0, 0});
        for (int k = 0; k < 10; k++)
            tbl.push_back('{4'b1000, 0, 0, 3'd4, (k >= 6) ? 2'd1 : 2'd0, 0});
        tbl.push_back('{4'b0000, 1, 0, 3'd3, 2'd0, 1});
        tbl.push_back('{4'b0000, 0, 0, 3'd3, 2'd0, 1});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_inmove", 8'(inmove), 8'd4);
        chk("rst_level", 8'(queue_level), 8'd0);
        chk("rst_started", 8'(started), 8'd0);
        @(negedge clk);
        resetButton_n = 1'b1;

        foreach (tbl[i]) begin
            v = tbl[i];
            btn = v.b; step_tick = v.t; game_over = v.g;
            cyc();
            chk($sformatf("tbl%0d_inmove", i), 8'(inmove), 8'(v.inm));
            chk($sformatf("tbl%0d_level", i), 8'(queue_level), 8'(v.lvl));
            chk($sformatf("tbl%0d_started", i), 8'(started), 8'(v.st));
        end
        btn = '0; step_tick = 1'b0;
        mchk = 1'b1;
        repeat (D + 4) cyc();

        // Bouncing right from home: one accepted press.
        do_reset();
        btn[0] = 1'b1; cyc();
        btn[0] = 1'b0; cyc();
        btn[0] = 1'b1; cyc();
        btn[0] = 1'b0; cyc();
        btn[0] = 1'b1;
        repeat (D + 4) cyc();
        btn[0] = 1'b0;
        repeat (D + 4) cyc();
        chk("bounce_level", 8'(queue_level), 8'd1);
        tick();
        chk("bounce_inmove", 8'(inmove), 8'd0);
        chk("bounce_started", 8'(started), 8'd1);

        // Left rejected as reversal, up accepted.
        press(2);
        chk("left_rej_level", 8'(queue_level), 8'd0);
        press(3);
        chk("up_acc_level", 8'(queue_level), 8'd1);
        tick();
        chk("up_inmove", 8'(inmove), 8'd3);

        // Back to +x, then down / up(rejected) / right.
        press(0);
        tick();
        chk("right_inmove", 8'(inmove), 8'd0);
        press(1);
        chk("down_level", 8'(queue_level), 8'd1);
        press(3);
        chk("up_rej_level", 8'(queue_level), 8'd1);
        press(0);
        chk("right_q_level", 8'(queue_level), 8'd2);
        tick();
        chk("pop1_inmove", 8'(inmove), 8'd1);
        tick();
        chk("pop2_inmove", 8'(inmove), 8'd0);
        chk("pop2_level", 8'(queue_level), 8'd0);

        // Full queue, then game_over with tick and a fresh press event.
        press(1);
        press(0);
        chk("full_level", 8'(queue_level), 8'd2);
        btn[3] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (m_deb[3] && !m_prev[3]) seen = 1'b1;
            else cyc();
        end
        chk("go_event_seen", 8'(seen), 8'd1);
        game_over = 1'b1; step_tick = 1'b1;
        cyc();
        game_over = 1'b0; step_tick = 1'b0;
        chk("go_inmove", 8'(inmove), 8'd4);
        chk("go_level", 8'(queue_level), 8'd0);
        chk("go_started", 8'(started), 8'd0);
        btn[3] = 1'b0;
        repeat (D + 4) cyc();

        // Reset mid-debounce while a direction is committed.
        press(0);
        tick();
        chk("pre_rst_started", 8'(started), 8'd1);
        btn[1] = 1'b1;
        repeat (3) cyc();
        #2;
        do_reset();
        repeat (D + 2) cyc();
        chk("post_rst_level0", 8'(queue_level), 8'd0);
        cyc();
        chk("post_rst_level1", 8'(queue_level), 8'd1);
        btn[1] = 1'b0;
        repeat (D + 4) cyc();

        // Randomized run.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(11) == 0) btn[i] = ~btn[i];
            step_tick = ($urandom_range(5) == 0);
            game_over = ($urandom_range(149) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
